level_ctrl: RTL and testbench
=============================

LEVEL_CTRL -- requirements
Module: level_ctrl

Interface
REQ-001 SHALL have parameter LEVEL_MIN, default 2, meaning the lowest level and the muted level.
REQ-002 SHALL have parameter LEVEL_MAX, default 13, meaning the highest level.
REQ-003 SHALL have parameter LEVEL_INIT, default 5, meaning the level after reset.
REQ-004 SHALL have parameter LW, default 4, meaning the level bus width.
REQ-005 SHALL have parameter DEB_LEN, default 4, meaning the number of consecutive equal samples needed to accept a button change.
REQ-006 SHALL have parameter REPEAT_DELAY, default 50, meaning the hold ticks before auto-repeat starts (0.5 s).
REQ-007 SHALL have parameter REPEAT_RATE, default 10, meaning the ticks between auto-repeat steps (0.1 s).
REQ-008 SHALL derive LED_W = LEVEL_MAX-LEVEL_MIN, which is 11 by default.
REQ-009 clk_100Hz  input  1  sole clock; all state updates on its rising edge.
REQ-010 reset  input  1  reset, asynchronous, active-high.
REQ-011 pb_up  input  1  raw volume-up button, active-high, asynchronous to clk_100Hz.
REQ-012 pb_down  input  1  raw volume-down button, active-high.
REQ-013 pb_mute  input  1  raw mute button, active-high.
REQ-014 level  output  LW  current level, LEVEL_MIN..LEVEL_MAX.
REQ-015 muted  output  1  high while mute is active.
REQ-016 led_bar  output  LED_W  thermometer code: bits [level-LEVEL_MIN-1:0] set, rest clear.
REQ-017 at_max / at_min  output  1 each  level==LEVEL_MAX / level==LEVEL_MIN.
REQ-018 changed  output  1  one-cycle pulse on the edge after level or muted changes.

Function
REQ-019 Each button SHALL be sampled into a DEB_LEN-deep shift register; the debounced state goes to 1 when all samples are 1 and to 0 when all are 0, and holds otherwise.
REQ-020 The debounced rising edge SHALL produce one step request, applied to level on the following edge (DEB_LEN+1 edges after raw input goes stable high).
REQ-021 Auto-repeat applies to up and down only. It uses a per-button FSM: IDLE -> (deb rise, issue step) HOLD -> (REPEAT_DELAY ticks held) RPT, issuing a step on entry and every REPEAT_RATE ticks after; any state -> IDLE on deb fall.
REQ-022 Up step SHALL increment level and saturate at LEVEL_MAX; down step SHALL decrement and saturate at LEVEL_MIN; a saturated request SHALL NOT pulse changed.
REQ-023 Mute press while unmuted SHALL save level into an internal register, set level=LEVEL_MIN and set muted=1.
REQ-024 Mute press while muted SHALL restore the saved level and clear muted.
REQ-025 An up or down request while muted SHALL unmute and restore the saved level without stepping.
REQ-026 When requests coincide on the same edge, mute SHALL beat up/down; up and down together SHALL be ignored (level unchanged, no changed pulse).
REQ-027 led_bar, at_max and at_min SHALL be combinational decodes of registered level.
REQ-028 Repeat counters SHALL be wide enough for max(REPEAT_DELAY,REPEAT_RATE) and SHALL NOT wrap while held; hold beyond RPT continues stepping and is bounded by saturation.

Reset
REQ-029 Reset SHALL give: level=LEVEL_INIT, saved level=LEVEL_INIT, muted=0, changed=0, all FSMs IDLE, shift registers and debounced states 0, counters 0.
REQ-030 A button held through reset deassertion SHALL be treated as a new press after DEB_LEN samples.
REQ-031 Reset asserted mid-hold or mid-repeat SHALL abort the step and leave no pending request.

Structure
REQ-032 Package level_ctrl_pkg SHALL hold the FSM state type (IDLE, HOLD, RPT) and the default parameter constants.
REQ-033 Sub-module pb_conditioner (debounce + edge + repeat FSM, parameter REPEAT_EN) SHALL be instantiated three times, with REPEAT_EN=0 for mute.
REQ-034 The level/mute datapath SHALL live in level_ctrl.

Verification
REQ-035 Bench SHALL apply reset, then pulse pb_up for 6 cycles -> level 5->6 on the 5th edge after the rise, led_bar=11'b00000001111, changed high for 1 cycle.
REQ-036 Bench SHALL hold pb_up for 200 cycles from level 5 -> steps at 0, 50, 60, 70 ... ticks, saturating at 13 with led_bar all ones and at_max=1, and no changed pulse after saturation.
REQ-037 Bench SHALL apply a 2-cycle glitch on pb_down (shorter than DEB_LEN) -> level unchanged, no changed pulse.
REQ-038 Bench SHALL set level 9, press mute -> level=2, muted=1, led_bar=0; then press down -> level=9, muted=0.
REQ-039 Bench SHALL drive pb_up and pb_down stable together -> level unchanged; pb_mute and pb_up together -> mute applied only.
REQ-040 Bench SHALL assert reset during RPT at level 11 -> level=5, muted=0, and no step on release.

Source files
------------

// File: rtl/level_ctrl_pkg.sv
// Shared types and default constants for the volume level controller.
// Holds the per-button FSM state type and the default parameter values.
package level_ctrl_pkg;

  localparam int DEF_LEVEL_MIN    = 2;
  localparam int DEF_LEVEL_MAX    = 13;
  localparam int DEF_LEVEL_INIT   = 5;
  localparam int DEF_LW           = 4;
  localparam int DEF_DEB_LEN      = 4;
  localparam int DEF_REPEAT_DELAY = 50;
  localparam int DEF_REPEAT_RATE  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } pb_state_t;

  // Debug view of all three button FSMs
  typedef struct packed {
    pb_state_t mute;
    pb_state_t down;
    pb_state_t up;
  } pb_states_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/level_ctrl_pb_conditioner.sv
// Push-button conditioner: shift-register debounce, press detection and
// optional hold-to-repeat FSM producing single-cycle step requests.
module pb_conditioner
  import level_ctrl_pkg::*;
#(
  parameter int DEB_LEN      = DEF_DEB_LEN,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      pb,
  output logic      step,
  output pb_state_t state
);

  localparam int CW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  logic [DEB_LEN-1:0] shreg;
  logic [DEB_LEN-1:0] shreg_nxt;
  logic               deb;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_nxt;
  pb_state_t          state_nxt;

  // deb follows the post-shift contents, so it settles on the DEB_LEN-th sample
  assign shreg_nxt = {shreg[DEB_LEN-2:0], pb};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      deb   <= 1'b0;
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      shreg <= shreg_nxt;
      if (&shreg_nxt) begin
        deb <= 1'b1;
      end else if (~|shreg_nxt) begin
        deb <= 1'b0;
      end
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Counter restarts at each threshold, so it never wraps while held
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (deb) begin
          step      = 1'b1;
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        if (!deb) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (REPEAT_EN) begin
          if (cnt == CW'(REPEAT_DELAY - 1)) begin
            step      = 1'b1;
            state_nxt = ST_RPT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      ST_RPT: begin
        if (!deb) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(REPEAT_RATE - 1)) begin
          step    = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/level_ctrl.sv
// Volume level controller: three conditioned buttons drive a saturating
// level with mute/restore, plus thermometer LED and limit decodes.
module level_ctrl
  import level_ctrl_pkg::*;
#(
  parameter int LEVEL_MIN    = DEF_LEVEL_MIN,
  parameter int LEVEL_MAX    = DEF_LEVEL_MAX,
  parameter int LEVEL_INIT   = DEF_LEVEL_INIT,
  parameter int LW           = DEF_LW,
  parameter int DEB_LEN      = DEF_DEB_LEN,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  localparam int LED_W       = LEVEL_MAX - LEVEL_MIN
) (
  input  logic             clk_100Hz,
  input  logic             reset,
  input  logic             pb_up,
  input  logic             pb_down,
  input  logic             pb_mute,
  output logic [LW-1:0]    level,
  output logic             muted,
  output logic [LED_W-1:0] led_bar,
  output logic             at_max,
  output logic             at_min,
  output logic             changed,
  output pb_states_t       dbg_state
);

  logic          step_up;
  logic          step_down;
  logic          step_mute;
  logic [LW-1:0] saved;
  logic [LW-1:0] level_nxt;
  logic [LW-1:0] saved_nxt;
  logic          muted_nxt;

  pb_conditioner #(
    .DEB_LEN(DEB_LEN), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
  ) u_up (
    .clk(clk_100Hz), .reset(reset), .pb(pb_up),
    .step(step_up), .state(dbg_state.up)
  );

  pb_conditioner #(
    .DEB_LEN(DEB_LEN), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
  ) u_down (
    .clk(clk_100Hz), .reset(reset), .pb(pb_down),
    .step(step_down), .state(dbg_state.down)
  );

  pb_conditioner #(
    .DEB_LEN(DEB_LEN), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0)
  ) u_mute (
    .clk(clk_100Hz), .reset(reset), .pb(pb_mute),
    .step(step_mute), .state(dbg_state.mute)
  );

  // Mute beats up/down; simultaneous up+down cancel; any step while muted restores
  always_comb begin
    level_nxt = level;
    saved_nxt = saved;
    muted_nxt = muted;
    if (step_mute) begin
      if (muted) begin
        level_nxt = saved;
        muted_nxt = 1'b0;
      end else begin
        saved_nxt = level;
        level_nxt = LW'(LEVEL_MIN);
        muted_nxt = 1'b1;
      end
    end else if (step_up ^ step_down) begin
      if (muted) begin
        level_nxt = saved;
        muted_nxt = 1'b0;
      end else if (step_up) begin
        if (level != LW'(LEVEL_MAX)) level_nxt = level + LW'(1);
      end else begin
        if (level != LW'(LEVEL_MIN)) level_nxt = level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      level   <= LW'(LEVEL_INIT);
      saved   <= LW'(LEVEL_INIT);
      muted   <= 1'b0;
      changed <= 1'b0;
    end else begin
      level   <= level_nxt;
      saved   <= saved_nxt;
      muted   <= muted_nxt;
      changed <= (level_nxt != level) || (muted_nxt != muted);
    end
  end

  always_comb begin
    led_bar = '0;
    for (int i = 0; i < LED_W; i++) begin
      led_bar[i] = (int'(level) - LEVEL_MIN) > i;
    end
  end

  assign at_max = (level == LW'(LEVEL_MAX));
  assign at_min = (level == LW'(LEVEL_MIN));

endmodule

// File: tb/tb_level_ctrl.sv
// Directed bench for level_ctrl: debounce latency, auto-repeat timing,
// saturation, glitch rejection, mute/restore, request priority and reset.
module tb_level_ctrl;
  import level_ctrl_pkg::*;

  logic        clk_100Hz;
  logic        reset;
  logic        pb_up;
  logic        pb_down;
  logic        pb_mute;
  logic [3:0]  level;
  logic        muted;
  logic [10:0] led_bar;
  logic        at_max;
  logic        at_min;
  logic        changed;
  pb_states_t  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int chg_cnt = 0;
  int chg_base;

  level_ctrl dut (
    .clk_100Hz(clk_100Hz), .reset(reset),
    .pb_up(pb_up), .pb_down(pb_down), .pb_mute(pb_mute),
    .level(level), .muted(muted), .led_bar(led_bar),
    .at_max(at_max), .at_min(at_min), .changed(changed),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk_100Hz = 1'b0;
  always #5 clk_100Hz = ~clk_100Hz;

  // changed pulse counter, sampled shortly after each rising edge
  always @(posedge clk_100Hz) begin
    #2;
    if (changed) chg_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_100Hz);
  endtask

  task automatic set_btns(input logic [2:0] b);
    {pb_mute, pb_down, pb_up} = b;
  endtask

  // hold buttons for n_high cycles, then release for n_low cycles
  task automatic press(input logic [2:0] b, input int n_high, input int n_low);
    set_btns(b);
    cycles(n_high);
    set_btns(3'b000);
    cycles(n_low);
  endtask

  function automatic int exp_hold(input int k);
    int steps;
    steps = 0;
    if (k >= 5) steps = 1;
    if (k >= 55) steps += 1 + (k - 55) / 10;
    return (5 + steps > 13) ? 13 : 5 + steps;
  endfunction

  initial begin
    reset = 1'b1;
    set_btns(3'b000);
    cycles(3);
    reset = 1'b0;
    cycles(1);

    // reset state
    check("rst_level", 32'(level), 32'd5);
    check("rst_muted", 32'(muted), 32'd0);
    check("rst_led", 32'(led_bar), 32'b00000000111);
    check("rst_limits", 32'({at_max, at_min}), 32'd0);
    check("rst_changed", 32'(changed), 32'd0);
    check("rst_fsm", 32'(dbg_state), 32'd0);

    // single press: step lands on the 5th edge after the rise
    chg_base = chg_cnt;
    set_btns(3'b001);
    cycles(4);
    check("up_pre_edge5", 32'(level), 32'd5);
    cycles(1);
    check("up_level", 32'(level), 32'd6);
    check("up_led", 32'(led_bar), 32'b00000001111);
    check("up_changed_hi", 32'(changed), 32'd1);
    cycles(1);
    check("up_changed_lo", 32'(changed), 32'd0);
    set_btns(3'b000);
    cycles(10);
    check("up_pulses", 32'(chg_cnt - chg_base), 32'd1);

    // back to 5, then hold up for 200 cycles
    press(3'b010, 6, 10);
    check("down_level", 32'(level), 32'd5);
    chg_base = chg_cnt;
    set_btns(3'b001);
    for (int k = 1; k <= 200; k++) begin
      cycles(1);
      check($sformatf("hold_k%0d", k), 32'(level), 32'(exp_hold(k)));
    end
    set_btns(3'b000);
    cycles(10);
    check("hold_pulses", 32'(chg_cnt - chg_base), 32'd8);
    check("hold_led", 32'(led_bar), 32'h7ff);
    check("hold_at_max", 32'(at_max), 32'd1);
    check("hold_fsm_idle", 32'(dbg_state), 32'd0);

    // short glitch on down is ignored
    chg_base = chg_cnt;
    press(3'b010, 2, 10);
    check("glitch_level", 32'(level), 32'd13);
    check("glitch_pulses", 32'(chg_cnt - chg_base), 32'd0);

    // down to 9, mute, then down restores
    for (int i = 0; i < 4; i++) press(3'b010, 6, 6);
    check("set9_level", 32'(level), 32'd9);
    press(3'b100, 6, 6);
    check("mute_level", 32'(level), 32'd2);
    check("mute_muted", 32'(muted), 32'd1);
    check("mute_led", 32'(led_bar), 32'd0);
    check("mute_at_min", 32'(at_min), 32'd1);
    press(3'b010, 6, 6);
    check("unmute_level", 32'(level), 32'd9);
    check("unmute_muted", 32'(muted), 32'd0);

    // up+down together cancel
    chg_base = chg_cnt;
    press(3'b011, 8, 8);
    check("updown_level", 32'(level), 32'd9);
    check("updown_pulses", 32'(chg_cnt - chg_base), 32'd0);

    // mute+up together: mute only
    press(3'b101, 8, 8);
    check("muteup_level", 32'(level), 32'd2);
    check("muteup_muted", 32'(muted), 32'd1);
    press(3'b100, 6, 6);
    check("remute_level", 32'(level), 32'd9);
    check("remute_muted", 32'(muted), 32'd0);

    // reset while repeating at level 11
    set_btns(3'b001);
    cycles(60);
    check("rpt_level", 32'(level), 32'd11);
    check("rpt_fsm", 32'(dbg_state.up), 32'(ST_RPT));
    reset = 1'b1;
    #1;
    check("rpt_rst_level", 32'(level), 32'd5);
    set_btns(3'b000);
    cycles(3);
    reset = 1'b0;
    chg_base = chg_cnt;
    cycles(20);
    check("rpt_after_level", 32'(level), 32'd5);
    check("rpt_after_muted", 32'(muted), 32'd0);
    check("rpt_after_pulses", 32'(chg_cnt - chg_base), 32'd0);

    // button held through reset release counts as a new press
    reset = 1'b1;
    set_btns(3'b001);
    cycles(2);
    reset = 1'b0;
    cycles(4);
    check("held_rst_pre", 32'(level), 32'd5);
    cycles(1);
    check("held_rst_step", 32'(level), 32'd6);
    set_btns(3'b000);
    cycles(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
